branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand, PC and target width, minimum 8.
REQ-002 SHALL have parameter BHT_DEPTH, default 64: number of 2-bit predictor counters, a power of two and at least 2.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid_i, input, 1 bit: request present.
REQ-006 SHALL have port in_ready_o, output, 1 bit: request accepted when high with in_valid_i.
REQ-007 SHALL have port cmp_op_i, input, 2 bits: 00 none, 01 compare, 10 always, 11 none.
REQ-008 SHALL have port cmp_funct_i, input, 3 bits: [2:1] 00 eq, 10 signed lt, 11 unsigned lt, 01 constant 0; [0] inverts the result.
REQ-009 SHALL have ports cmp_num1_i and cmp_num2_i, inputs, XLEN bits each: the operands.
REQ-010 SHALL have ports pc_i and target_i, inputs, XLEN bits each: instruction PC and precomputed taken target.
REQ-011 SHALL have ports pred_taken_i (1 bit) and pred_target_i (XLEN bits), inputs: the fetch prediction.
REQ-012 SHALL have port flush_i, input, 1 bit: discard the held result and any request accepted in the same cycle.
REQ-013 SHALL have ports out_valid_o (output) and out_ready_i (input), 1 bit each: result handshake.
REQ-014 SHALL have ports taken_o, redirect_o and is_cond_o, outputs, 1 bit each: resolved direction, mispredict, and whether the op was a compare.
REQ-015 SHALL have port redirect_pc_o, output, XLEN bits: the correct next PC.
REQ-016 SHALL have ports lookup_pc_i (input, XLEN bits) and lookup_taken_o (output, 1 bit): predictor read port.

Function
REQ-017 SHALL hold in_ready_o = !out_valid_o || out_ready_i || flush_i, combinationally.
REQ-018 SHALL register the result on an in_valid_i && in_ready_o cycle with flush_i low, giving 1-cycle latency and out_valid_o=1 on the next cycle.
REQ-019 SHALL compute taken as: op 00/11 -> 0; op 10 -> 1; op 01 -> (base compare per cmp_funct_i[2:1]) XOR cmp_funct_i[0], full XLEN width.
REQ-020 SHALL set redirect_pc_o = target_i when taken, otherwise pc_i + 4 modulo 2^XLEN (wraps silently).
REQ-021 SHALL set redirect_o = (taken != pred_taken_i) || (taken && target_i != pred_target_i).
REQ-022 SHALL keep out_valid_o and all result outputs stable while out_valid_o && !out_ready_i && !flush_i.
REQ-023 SHALL clear out_valid_o next cycle when out_ready_i completes the handshake and no new request is accepted.
REQ-024 SHALL, when flush_i is high, set out_valid_o=0 next cycle, drop any request accepted that cycle, and perform no predictor update.
REQ-025 SHALL index the predictor by pc[log2(BHT_DEPTH)+1:2].
REQ-026 SHALL update the counter only on an out_valid_o && out_ready_i && !flush_i cycle with is_cond_o=1: taken -> saturating increment (max 3), not taken -> saturating decrement (min 0).
REQ-027 SHALL make lookup_taken_o combinationally equal to bit 1 of the indexed counter; a same-cycle update is not forwarded (pre-update value returned).

Reset
REQ-028 SHALL, on a clock edge with rst_n_i=0, force out_valid_o=0, taken_o=0, redirect_o=0, is_cond_o=0, redirect_pc_o=0 and every counter to 2'b01.
REQ-029 SHALL discard any request presented during reset; in_ready_o SHALL NOT be relied upon while rst_n_i=0.

Verification
REQ-030 SHALL cover this case: XLEN=32, op=01, funct=100 (blt), num1=0xFFFFFFFF, num2=1, pred_taken=0 -> taken_o=1, redirect_o=1, redirect_pc_o=target_i; with funct=110 (bltu) -> taken_o=0, redirect_o=0.
REQ-031 SHALL cover this case: op=10, pred_taken=1, pred_target != target_i -> redirect_o=1; pc_i=0xFFFFFFFC with op=00 -> redirect_pc_o=0x00000000.
REQ-032 SHALL cover this case: out_ready_i held 0 for 3 cycles with in_valid_i held high -> outputs stable, in_ready_o=0, then exactly one transfer per cycle once ready returns.
REQ-033 SHALL cover this case: after reset, lookup_taken_o=0; three resolved taken beq at pc 0x100 -> counter 1->2->3->3, lookup_taken_o=1 after the first; four not-taken -> saturates at 0.
REQ-034 SHALL cover this case: flush_i asserted with out_valid_o=1 and out_ready_i=1 plus a new request -> out_valid_o=0 next cycle, counter unchanged.
REQ-035 SHALL cover this case: rst_n_i low mid-stall -> out_valid_o=0 and all counters at 01 on the following cycle.

Source files
------------

// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates the branch condition, checks it against the
// fetch prediction, and trains a table of 2-bit saturating counters.
module branch_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      cmp_op_i,
  input  logic [2:0]      cmp_funct_i,
  input  logic [XLEN-1:0] cmp_num1_i,
  input  logic [XLEN-1:0] cmp_num2_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_target_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            taken_o,
  output logic            redirect_o,
  output logic            is_cond_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            lookup_taken_o
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic             out_valid_q, out_valid_d;
  logic             taken_q, taken_d;
  logic             redirect_q, redirect_d;
  logic             is_cond_q, is_cond_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [IDX_W-1:0] upd_idx_q, upd_idx_d;

  logic             accept;
  logic             bht_upd;
  logic             base_cmp;
  logic             taken_c;
  logic [XLEN-1:0]  seq_pc;
  logic [BHT_DEPTH-1:0] cnt_msb;
  logic             unused_lookup_bits;

  assign in_ready_o = !out_valid_q || out_ready_i || flush_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  // Train only on a result that actually leaves the unit unflushed.
  assign bht_upd    = out_valid_q && out_ready_i && !flush_i && is_cond_q;
  assign seq_pc     = pc_i + XLEN'(4);

  always_comb begin
    base_cmp = 1'b0;
    case (cmp_funct_i[2:1])
      2'b00:   base_cmp = (cmp_num1_i == cmp_num2_i);
      2'b10:   base_cmp = ($signed(cmp_num1_i) < $signed(cmp_num2_i));
      2'b11:   base_cmp = (cmp_num1_i < cmp_num2_i);
      default: base_cmp = 1'b0;
    endcase
    case (cmp_op_i)
      2'b01:   taken_c = base_cmp ^ cmp_funct_i[0];
      2'b10:   taken_c = 1'b1;
      default: taken_c = 1'b0;
    endcase
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    taken_d       = taken_q;
    redirect_d    = redirect_q;
    is_cond_d     = is_cond_q;
    redirect_pc_d = redirect_pc_q;
    upd_idx_d     = upd_idx_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      taken_d       = taken_c;
      redirect_d    = (taken_c != pred_taken_i) || (taken_c && (target_i != pred_target_i));
      is_cond_d     = (cmp_op_i == 2'b01);
      redirect_pc_d = taken_c ? target_i : seq_pc;
      upd_idx_d     = pc_i[IDX_W+1:2];
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_valid_q   <= 1'b0;
      taken_q       <= 1'b0;
      redirect_q    <= 1'b0;
      is_cond_q     <= 1'b0;
      redirect_pc_q <= '0;
      upd_idx_q     <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      taken_q       <= taken_d;
      redirect_q    <= redirect_d;
      is_cond_q     <= is_cond_d;
      redirect_pc_q <= redirect_pc_d;
      upd_idx_q     <= upd_idx_d;
    end
  end

  generate
    for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
      logic [1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (bht_upd && (upd_idx_q == IDX_W'(gi))) begin
          if (taken_q) begin
            if (cnt_q != 2'b11) cnt_d = cnt_q + 2'd1;
          end else begin
            if (cnt_q != 2'b00) cnt_d = cnt_q - 2'd1;
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (!rst_n_i) cnt_q <= 2'b01;
        else          cnt_q <= cnt_d;
      end

      assign cnt_msb[gi] = cnt_q[1];
    end
  endgenerate

  // Lookup reads the registered counters, so a same-cycle update is not visible.
  assign lookup_taken_o     = cnt_msb[lookup_pc_i[IDX_W+1:2]];
  assign unused_lookup_bits = ^{lookup_pc_i[XLEN-1:IDX_W+2], lookup_pc_i[1:0]};

  assign out_valid_o   = out_valid_q;
  assign taken_o       = taken_q;
  assign redirect_o    = redirect_q;
  assign is_cond_o     = is_cond_q;
  assign redirect_pc_o = redirect_pc_q;
endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: directed table, multi-cycle corner sequences and random
// traffic compared against a transaction-level reference model.
module tb_branch_unit;
  localparam int XLEN = 32;
  localparam int BHT  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [1:0]  op;
  logic [2:0]  funct;
  logic [31:0] n1, n2, pc, tgt, ptg, rpc, lookup_pc;
  logic        pt, taken, redirect, is_cond, lookup_taken;

  branch_unit #(.XLEN(XLEN), .BHT_DEPTH(BHT)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .cmp_op_i(op), .cmp_funct_i(funct), .cmp_num1_i(n1), .cmp_num2_i(n2),
    .pc_i(pc), .target_i(tgt), .pred_taken_i(pt), .pred_target_i(ptg),
    .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .taken_o(taken), .redirect_o(redirect), .is_cond_o(is_cond),
    .redirect_pc_o(rpc), .lookup_pc_i(lookup_pc), .lookup_taken_o(lookup_taken)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the pending result plus a plain integer per counter.
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic        redir;
    logic        is_cond;
    logic [31:0] rpc;
    logic [31:0] pc;
  } res_t;
  res_t m;
  int   ctr [BHT];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % BHT);
  endfunction

  function automatic logic ref_taken(input logic [1:0] o, input logic [2:0] f,
                                     input logic [31:0] a, input logic [31:0] b);
    logic r;
    if (o == 2'b10) return 1'b1;
    if (o != 2'b01) return 1'b0;
    if (f[2:1] == 2'b00)      r = (a == b);
    else if (f[2:1] == 2'b10) r = ($signed(a) < $signed(b));
    else if (f[2:1] == 2'b11) r = (a < b);
    else                      r = 1'b0;
    return r ^ f[0];
  endfunction

  always @(posedge clk) begin
    logic rdy;
    logic t;
    int   k;
    if (!rst_n) begin
      m = '0;
      foreach (ctr[i]) ctr[i] = 1;
    end else begin
      rdy = !m.valid || out_ready || flush;
      if (m.valid && out_ready && !flush && m.is_cond) begin
        k = idx_of(m.pc);
        if (m.taken) ctr[k] = (ctr[k] >= 3) ? 3 : ctr[k] + 1;
        else         ctr[k] = (ctr[k] <= 0) ? 0 : ctr[k] - 1;
      end
      if (flush) begin
        m.valid = 1'b0;
      end else if (in_valid && rdy) begin
        t         = ref_taken(op, funct, n1, n2);
        m.valid   = 1'b1;
        m.taken   = t;
        m.redir   = (t != pt) || (t && (tgt != ptg));
        m.is_cond = (op == 2'b01);
        m.rpc     = t ? tgt : pc + 32'd4;
        m.pc      = pc;
      end else if (out_ready) begin
        m.valid = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("in_ready", 64'(in_ready), 64'(!m.valid || out_ready || flush));
    chk("out_valid", 64'(out_valid), 64'(m.valid));
    chk("lookup_taken", 64'(lookup_taken), 64'(ctr[idx_of(lookup_pc)] >= 2));
    if (m.valid) begin
      chk("taken", 64'(taken), 64'(m.taken));
      chk("redirect", 64'(redirect), 64'(m.redir));
      chk("is_cond", 64'(is_cond), 64'(m.is_cond));
      chk("redirect_pc", 64'(rpc), 64'(m.rpc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] o, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, input logic [31:0] t,
                         input logic pt_v, input logic [31:0] ptg_v);
    op = o; funct = f; n1 = a; n2 = b; pc = p; tgt = t; pt = pt_v; ptg = ptg_v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    set_req(2'b10, 3'b000, 0, 0, 32'h100, 32'h900, 1'b0, 0);
    tick(); tick();
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_taken", 64'(taken), 64'd0);
    chk("rst_redirect", 64'(redirect), 64'd0);
    chk("rst_is_cond", 64'(is_cond), 64'd0);
    chk("rst_redirect_pc", 64'(rpc), 64'd0);
    chk("rst_lookup", 64'(lookup_taken), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  // One compare branch, accepted and then consumed, so the counter trains once.
  task automatic resolve(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p);
    set_req(2'b01, f, a, b, p, p + 32'h40, 1'b0, 0);
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    #1 check_model();
    tick();
    in_valid = 1'b0;
    #1 check_model();
    tick();
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  fn;
    logic [31:0] a, b, pc, tgt;
    logic        pt;
    logic [31:0] ptg;
    logic        e_taken, e_redir;
    logic [31:0] e_rpc;
  } vec_t;
  vec_t tbl [10];

  logic [31:0] held_rpc;
  bit   pt_seq [7];

  initial begin
    tbl[0] = '{2'b01, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h300, 1'b0, 32'h0,   1'b1, 1'b1, 32'h300};
    tbl[1] = '{2'b01, 3'b110, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h300, 1'b0, 32'h0,   1'b0, 1'b0, 32'h204};
    tbl[2] = '{2'b10, 3'b000, 32'd0, 32'd0, 32'h10, 32'h500, 1'b1, 32'h400,         1'b1, 1'b1, 32'h500};
    tbl[3] = '{2'b00, 3'b000, 32'd0, 32'd0, 32'hFFFFFFFC, 32'h8, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0};
    tbl[4] = '{2'b01, 3'b000, 32'd5, 32'd5, 32'h40, 32'h80, 1'b1, 32'h80,           1'b1, 1'b0, 32'h80};
    tbl[5] = '{2'b01, 3'b001, 32'd5, 32'd5, 32'h40, 32'h80, 1'b1, 32'h80,           1'b0, 1'b1, 32'h44};
    tbl[6] = '{2'b01, 3'b011, 32'd1, 32'd2, 32'h20, 32'h60, 1'b0, 32'h0,            1'b1, 1'b1, 32'h60};
    tbl[7] = '{2'b11, 3'b100, 32'd0, 32'd9, 32'h30, 32'h70, 1'b0, 32'h0,            1'b0, 1'b0, 32'h34};
    tbl[8] = '{2'b01, 3'b101, 32'hFFFFFFFF, 32'd1, 32'h50, 32'h90, 1'b0, 32'h0,     1'b0, 1'b0, 32'h54};
    tbl[9] = '{2'b10, 3'b000, 32'd0, 32'd0, 32'h60, 32'hA0, 1'b1, 32'hA0,           1'b1, 1'b0, 32'hA0};
    pt_seq = '{1, 1, 1, 1, 0, 0, 0};

    lookup_pc = 32'h100;
    do_reset();

    // Directed table: one accepted request, result checked the next cycle.
    foreach (tbl[i]) begin
      set_req(tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].pc, tbl[i].tgt, tbl[i].pt, tbl[i].ptg);
      in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
      #1 check_model();
      tick();
      in_valid = 1'b0;
      #1;
      chk("tbl_out_valid", 64'(out_valid), 64'd1);
      chk("tbl_taken", 64'(taken), 64'(tbl[i].e_taken));
      chk("tbl_redirect", 64'(redirect), 64'(tbl[i].e_redir));
      chk("tbl_redirect_pc", 64'(rpc), 64'(tbl[i].e_rpc));
      chk("tbl_is_cond", 64'(is_cond), 64'(tbl[i].op == 2'b01));
      check_model();
      $display("vec %0d: op=%b funct=%b taken=%0b redirect=%0b redirect_pc=%08h",
               i, tbl[i].op, tbl[i].fn, taken, redirect, rpc);
      tick();
    end

    // Predictor training at 0x100: three taken then four not-taken.
    do_reset();
    lookup_pc = 32'h100;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) resolve(3'b000, 32'd7, 32'd7, 32'h100);
      else       resolve(3'b000, 32'd7, 32'd8, 32'h100);
      #1;
      chk("bht_train", 64'(lookup_taken), 64'(pt_seq[i]));
      $display("train %0d: lookup_taken=%0b", i, lookup_taken);
    end

    // Flush with a pending result, ready high and a new request in the same cycle.
    do_reset();
    lookup_pc = 32'h180;
    set_req(2'b01, 3'b000, 32'd3, 32'd3, 32'h180, 32'h1C0, 1'b0, 0);
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    #1 check_model();
    tick();
    set_req(2'b10, 3'b000, 0, 0, 32'h500, 32'h600, 1'b0, 0);
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    #1 check_model();
    tick();
    in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_no_train", 64'(lookup_taken), 64'd0);
    check_model();
    $display("flush: out_valid=%0b lookup_taken=%0b", out_valid, lookup_taken);
    tick();

    // Back-pressure: hold ready low three cycles with a request waiting.
    do_reset();
    set_req(2'b00, 3'b000, 0, 0, 32'h1000, 32'h0, 1'b0, 0);
    in_valid = 1'b1; out_ready = 1'b0;
    #1 check_model();
    tick();
    set_req(2'b00, 3'b000, 0, 0, 32'h2000, 32'h0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_redirect_pc", 64'(rpc), 64'h1004);
      check_model();
      tick();
    end
    out_ready = 1'b1;
    #1 chk("stall_release_ready", 64'(in_ready), 64'd1);
    tick();
    set_req(2'b00, 3'b000, 0, 0, 32'h3000, 32'h0, 1'b0, 0);
    #1;
    chk("xfer1_valid", 64'(out_valid), 64'd1);
    chk("xfer1_pc", 64'(rpc), 64'h2004);
    check_model();
    tick();
    in_valid = 1'b0;
    #1;
    chk("xfer2_valid", 64'(out_valid), 64'd1);
    chk("xfer2_pc", 64'(rpc), 64'h3004);
    check_model();
    tick();
    #1 chk("xfer_drain", 64'(out_valid), 64'd0);
    $display("stall: drained, out_valid=%0b", out_valid);

    // Reset arriving while a result is stalled restores counters to weakly not-taken.
    do_reset();
    lookup_pc = 32'h100;
    resolve(3'b000, 32'd1, 32'd1, 32'h100);
    #1 chk("pre_rst_lookup", 64'(lookup_taken), 64'd1);
    set_req(2'b00, 3'b000, 0, 0, 32'h700, 32'h0, 1'b0, 0);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    #1 chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_lookup", 64'(lookup_taken), 64'd0);
    check_model();
    resolve(3'b000, 32'd1, 32'd1, 32'h100);
    #1 chk("midrst_cnt01", 64'(lookup_taken), 64'd1);
    $display("midrst: lookup_taken=%0b", lookup_taken);

    // Random traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      op        = 2'($urandom);
      funct     = 3'($urandom);
      n1        = $urandom;
      n2        = ($urandom_range(0, 1) == 0) ? n1 : $urandom;
      pc        = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'h1FC);
      tgt       = $urandom & 32'hFFFFFFFC;
      pt        = 1'($urandom);
      ptg       = ($urandom_range(0, 1) == 0) ? tgt : $urandom;
      lookup_pc = $urandom & 32'h1FC;
      #1 check_model();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
